// File: rtl/sram_burst_ctrl.sv
// sram_burst_ctrl: burst request controller in front of a single-port SRAM.
// Accepts read/write burst commands and runs one SRAM access per beat.
// Each beat completes on mem_resp. A beat that waits too long for
// mem_resp aborts the burst with an err pulse.
module sram_burst_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 14,
  parameter int LEN_WIDTH  = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  done,
  output logic                  err,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  input  logic                  mem_resp
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WFETCH = 2'd1,
    WRITE  = 2'd2,
    READ   = 2'd3
  } state_t;

  state_t                state_r,       state_s;
  logic [ADDR_WIDTH-1:0] addr_r,        addr_s;
  logic [LEN_WIDTH-1:0]  beat_r,        beat_s;
  logic [TMO_W-1:0]      tmo_r,         tmo_s;
  logic [DATA_WIDTH-1:0] wreg_r,        wreg_s;
  logic [DATA_WIDTH-1:0] rd_data_r,     rd_data_s;
  logic                  rd_valid_r,    rd_valid_s;
  logic                  rd_last_r,     rd_last_s;
  logic                  done_r,        done_s;
  logic                  err_r,         err_s;
  logic                  req_ready_r;
  logic                  wdata_ready_r;
  logic                  mem_re_r;
  logic                  mem_we_r;

  // Next-state and datapath decisions for the beat sequencer.
  always_comb begin
    state_s    = state_r;
    addr_s     = addr_r;
    beat_s     = beat_r;
    tmo_s      = tmo_r;
    wreg_s     = wreg_r;
    rd_data_s  = rd_data_r;
    rd_valid_s = 1'b0;
    rd_last_s  = 1'b0;
    done_s     = 1'b0;
    err_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid && req_ready_r) begin
          addr_s  = req_addr;
          beat_s  = req_len;
          tmo_s   = TMO_W'(0);
          state_s = req_write ? WFETCH : READ;
        end else begin
          state_s = IDLE;
        end
      end
      WFETCH: begin
        // Client may stall here indefinitely; no timeout counting.
        if (wdata_valid && wdata_ready_r) begin
          wreg_s  = wdata;
          tmo_s   = TMO_W'(0);
          state_s = WRITE;
        end else begin
          state_s = WFETCH;
        end
      end
      WRITE: begin
        if (mem_resp) begin
          if (beat_r == LEN_WIDTH'(0)) begin
            done_s  = 1'b1;
            state_s = IDLE;
          end else begin
            beat_s  = beat_r - LEN_WIDTH'(1);
            addr_s  = addr_r + ADDR_WIDTH'(1);
            tmo_s   = TMO_W'(0);
            state_s = WFETCH;
          end
        end else if (tmo_r == TMO_W'(TIMEOUT - 1)) begin
          err_s   = 1'b1;
          state_s = IDLE;
        end else begin
          tmo_s = tmo_r + TMO_W'(1);
        end
      end
      READ: begin
        if (mem_resp) begin
          rd_data_s  = mem_data;
          rd_valid_s = 1'b1;
          rd_last_s  = (beat_r == LEN_WIDTH'(0));
          if (beat_r == LEN_WIDTH'(0)) begin
            done_s  = 1'b1;
            state_s = IDLE;
          end else begin
            beat_s  = beat_r - LEN_WIDTH'(1);
            addr_s  = addr_r + ADDR_WIDTH'(1);
            tmo_s   = TMO_W'(0);
            state_s = READ;
          end
        end else if (tmo_r == TMO_W'(TIMEOUT - 1)) begin
          err_s   = 1'b1;
          state_s = IDLE;
        end else begin
          tmo_s = tmo_r + TMO_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register plus registered outputs; strobes follow the next state
  // so they are glitch-free and line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      addr_r        <= '0;
      beat_r        <= '0;
      tmo_r         <= '0;
      wreg_r        <= '0;
      rd_data_r     <= '0;
      rd_valid_r    <= 1'b0;
      rd_last_r     <= 1'b0;
      done_r        <= 1'b0;
      err_r         <= 1'b0;
      req_ready_r   <= 1'b0;
      wdata_ready_r <= 1'b0;
      mem_re_r      <= 1'b0;
      mem_we_r      <= 1'b0;
    end else begin
      state_r       <= state_s;
      addr_r        <= addr_s;
      beat_r        <= beat_s;
      tmo_r         <= tmo_s;
      wreg_r        <= wreg_s;
      rd_data_r     <= rd_data_s;
      rd_valid_r    <= rd_valid_s;
      rd_last_r     <= rd_last_s;
      done_r        <= done_s;
      err_r         <= err_s;
      req_ready_r   <= (state_s == IDLE);
      wdata_ready_r <= (state_s == WFETCH);
      mem_re_r      <= (state_s == READ);
      mem_we_r      <= (state_s == WRITE);
    end
  end

  // The bus is driven only while the write strobe is up, which by
  // construction excludes the read strobe.
  assign mem_data    = mem_we_r ? wreg_r : {DATA_WIDTH{1'bz}};

  assign req_ready   = req_ready_r;
  assign wdata_ready = wdata_ready_r;
  assign rd_valid    = rd_valid_r;
  assign rd_data     = rd_data_r;
  assign rd_last     = rd_last_r;
  assign done        = done_r;
  assign err         = err_r;
  assign mem_re      = mem_re_r;
  assign mem_we      = mem_we_r;
  assign mem_addr    = addr_r;

endmodule
